sub_bytes_engine: RTL

- Iterative AES SubBytes / InvSubBytes unit for a full multi-byte state word.
- Holds LANES parallel substitution lanes; each lane is selectable per transaction between the forward S-box and the inverse S-box (FIPS-197).
- Walks the word LANES bytes per cycle.
- Sits between the round controller and ShiftRows/MixColumns, and in the key-schedule path. Uses a valid/ready handshake on both sides so the cipher core can trade area (LANES) against latency.

---
 rtl/sub_bytes_engine_if.sv | 24 ++
 rtl/sub_bytes_engine.sv | 135 +++++++++++++
 2 files changed

// File: rtl/sub_bytes_engine_if.sv
// Word-level valid/ready stream into and out of the SubBytes engine.
// The engine attaches to the slave modport and the round controller to the master modport.
interface sub_bytes_engine_if #(
    parameter int unsigned DATA_BYTES = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_inv;
    logic [8*DATA_BYTES-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [8*DATA_BYTES-1:0] out_data;
    logic                    busy;

    modport slave (
        input  in_valid, in_inv, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_inv, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes/InvSubBytes: substitutes LANES bytes of the latched word per cycle,
// using the forward or inverse S-box as chosen when the word is accepted.
module sub_bytes_engine #(
    parameter int unsigned DATA_BYTES = 16,
    parameter int unsigned LANES      = 4
) (
    input logic               clk,
    input logic               rst,
    sub_bytes_engine_if.slave bus
);
    localparam int unsigned BEATS = DATA_BYTES / LANES;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (DATA_BYTES < 1 || LANES < 1 || (DATA_BYTES % LANES) != 0) begin : g_bad_params
        $error("sub_bytes_engine: DATA_BYTES must be >= 1 and a multiple of LANES");
    end

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        beat;
    logic                    mode;
    logic [8*DATA_BYTES-1:0] work, work_next;
    logic                    in_ready_c, out_valid_c, busy_c;
    logic                    last_beat;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254, which also maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01;
        p = a;
        e = 8'd254;
        for (int unsigned i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    assign last_beat = (beat == CNT_W'(BEATS - 1));

    always_comb begin
        state_next  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_next = SUB;
            end
            SUB: begin
                busy_c = 1'b1;
                if (last_beat) state_next = DONE;
            end
            DONE: begin
                busy_c      = 1'b1;
                out_valid_c = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Lane l of the current beat owns byte beat*LANES+l; every other byte passes through
    always_comb begin
        int unsigned idx;
        logic [7:0]  byte_in;
        work_next = work;
        idx       = 0;
        byte_in   = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            idx     = 32'(beat) * LANES + l;
            byte_in = work[idx*8 +: 8];
            work_next[idx*8 +: 8] = mode ? sbox_inv(byte_in) : sbox_fwd(byte_in);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
            mode  <= 1'b0;
            work  <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        work <= bus.in_data;
                        mode <= bus.in_inv;
                        beat <= '0;
                    end
                end
                SUB: begin
                    work <= work_next;
                    if (!last_beat) beat <= beat + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.out_data  = work;
endmodule
